// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath, game controller and text overlay.
//   pong_state_t : game state encoding (also exported on the controller's state port)
//   DEF_TICK_Y/X : scan position where the once-per-frame tick fires
//   FRAME_HZ     : frame rate; the default post-point wait is two seconds of frames
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } pong_state_t;

    localparam int DEF_TICK_Y       = 481;
    localparam int DEF_TICK_X       = 0;
    localparam int FRAME_HZ         = 60;
    localparam int DEF_TIMER_FRAMES = 2 * FRAME_HZ;
    localparam int TIMER_W          = 8;

    // Scores stop at 15 rather than wrapping back to 0.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-count down timer.
//   clk, reset : pixel clock, async active-high reset (count clears to 0)
//   load       : reload with TIMER_FRAMES; wins over a coincident tick
//   tick       : one-cycle frame pulse; decrements while nonzero
//   done       : count has reached zero
module pong_frame_timer #(
    parameter int TIMER_FRAMES = 120,
    parameter int W            = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= W'(TIMER_FRAMES);
        else if (tick && count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for two-player pong: serve/point/game-over FSM,
// score keeping and frame-based waits.
//   clk, reset     : pixel clock, async active-high reset
//   btn[3:0]       : raw player buttons (asynchronous), any press serves
//   x, y           : current scan position, used to derive the frame tick
//   pts_1, pts_2   : level "ball left the field" flags from pong_graph
//   gra_still      : freeze ball/paddles whenever not in PLAY
//   score_1/2      : binary scores
//   game_over      : high in OVER; winner valid while it is high
//   state          : current state for overlay text selection
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int TIMER_FRAMES = DEF_TIMER_FRAMES,
    parameter int TICK_Y       = DEF_TICK_Y,
    parameter int TICK_X       = DEF_TICK_X
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] state
);

    logic [3:0]  btn_meta, btn_sync;
    logic        any_btn, tick, timer_load, timer_done;
    pong_state_t state_q, state_d;
    logic [3:0]  score_1_d, score_2_d;
    logic        winner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    assign any_btn = |btn_sync;
    assign tick    = (y == 10'(TICK_Y)) && (x == 10'(TICK_X));

    pong_frame_timer #(
        .TIMER_FRAMES (TIMER_FRAMES),
        .W            (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .tick  (tick),
        .done  (timer_done)
    );

    // Leaving PLAY happens on the first cycle pts_* is seen, so a level that
    // stays high while the ball is off-screen scores only once.
    always_comb begin
        state_d    = state_q;
        score_1_d  = score_1;
        score_2_d  = score_2;
        winner_d   = winner;
        timer_load = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                score_1_d = '0;
                score_2_d = '0;
                if (any_btn) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (pts_1 && pts_2) begin
                    state_d    = ST_NEWBALL;
                    timer_load = 1'b1;
                end else if (pts_1) begin
                    score_1_d  = score_inc(score_1);
                    timer_load = 1'b1;
                    if (score_1_d == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d  = ST_NEWBALL;
                    end
                end else if (pts_2) begin
                    score_2_d  = score_inc(score_2);
                    timer_load = 1'b1;
                    if (score_2_d == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d  = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                // A button held through the wait serves the moment it ends.
                if (timer_done && any_btn) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (timer_done) begin
                    state_d   = ST_NEWGAME;
                    score_1_d = '0;
                    score_2_d = '0;
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NEWGAME;
            score_1 <= '0;
            score_2 <= '0;
            winner  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_1 <= score_1_d;
            score_2 <= score_2_d;
            winner  <= winner_d;
        end
    end

    assign state     = state_q;
    assign gra_still = (state_q != ST_PLAY);
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    localparam int WIN = 5;
    localparam int TF  = 120;
    localparam int TY  = 481;
    localparam int TX  = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [9:0] x, y;
    logic       pts_1, pts_2;
    logic       gra_still, game_over, winner;
    logic [3:0] score_1, score_2;
    logic [1:0] state;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .TIMER_FRAMES (TF),
        .TICK_Y       (TY),
        .TICK_X       (TX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .x         (x),
        .y         (y),
        .pts_1     (pts_1),
        .pts_2     (pts_2),
        .gra_still (gra_still),
        .score_1   (score_1),
        .score_2   (score_2),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       still;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       over;
        logic       win;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: game rules in plain integers, buttons delayed by a
    // two-entry history queue.
    int       m_st, m_s1, m_s2, m_win, m_tmr;
    bit [3:0] bhist[$];
    int       cyc_n = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = state; o.still = gra_still; o.s1 = score_1; o.s2 = score_2;
        o.over = game_over; o.win = winner;
        return o;
    endfunction

    function automatic obs_t m_obs();
        obs_t o;
        o.st    = 2'(m_st);
        o.still = (m_st != 1);
        o.s1    = 4'(m_s1);
        o.s2    = 4'(m_s2);
        o.over  = (m_st == 3);
        o.win   = m_win[0];
        return o;
    endfunction

    function automatic void show_fail(string name, obs_t a, obs_t e);
        $display("FAIL %s @%0t: got st=%0d still=%0d s1=%0d s2=%0d over=%0d win=%0d, want st=%0d still=%0d s1=%0d s2=%0d over=%0d win=%0d",
                 name, $time, a.st, a.still, a.s1, a.s2, a.over, a.win,
                 e.st, e.still, e.s1, e.s2, e.over, e.win);
    endfunction

    task automatic m_reset();
        m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_tmr = 0;
        bhist.delete();
        bhist.push_back(4'd0);
        bhist.push_back(4'd0);
    endtask

    // One clock of stimulus; the expected outputs after the coming edge are queued.
    task automatic step(input bit [3:0] b, input bit p1, input bit p2, input bit tk);
        bit any, done, load;
        @(negedge clk);
        reset = 1'b0; btn = b; pts_1 = p1; pts_2 = p2;
        if (tk) begin
            x = 10'(TX); y = 10'(TY);
        end else begin
            y = 10'($urandom_range(0, 480)); x = 10'($urandom_range(0, 799));
        end
        any  = (bhist.pop_front() != 4'd0);
        bhist.push_back(b);
        done = (m_tmr == 0);
        load = 1'b0;
        case (m_st)
            0: begin
                m_s1 = 0; m_s2 = 0;
                if (any) m_st = 1;
            end
            1: begin
                if (p1 && p2) begin
                    m_st = 2; load = 1'b1;
                end else if (p1) begin
                    m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                    load = 1'b1;
                    if (m_s1 == WIN) begin m_st = 3; m_win = 0; end
                    else m_st = 2;
                end else if (p2) begin
                    m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                    load = 1'b1;
                    if (m_s2 == WIN) begin m_st = 3; m_win = 1; end
                    else m_st = 2;
                end
            end
            2: if (done && any) m_st = 1;
            default: if (done) begin m_st = 0; m_s1 = 0; m_s2 = 0; end
        endcase
        if (load) m_tmr = TF;
        else if (tk && m_tmr > 0) m_tmr = m_tmr - 1;
        exp_q.push_back(m_obs());
    endtask

    // Frame tick every fourth clock keeps the 120-frame waits short.
    task automatic tstep(input bit [3:0] b, input bit p1, input bit p2);
        step(b, p1, p2, (cyc_n % 4) == 0);
        cyc_n++;
    endtask

    // Asynchronous reset in the middle of a clock low phase, checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1; btn = '0; pts_1 = 1'b0; pts_2 = 1'b0;
        m_reset();
        #1;
        tests++;
        if (dut_obs() !== m_obs()) begin
            fails++;
            show_fail("async_reset", dut_obs(), m_obs());
        end
        exp_q.push_back(m_obs());
    endtask

    task automatic wait_state(input int target, input bit [3:0] b, input string name);
        for (int i = 0; i < 3000 && m_st != target; i++) tstep(b, 1'b0, 1'b0);
        tests++;
        if (m_st != target) begin
            fails++;
            $display("FAIL %s: wait budget expired, model state %0d, want %0d", name, m_st, target);
        end
    endtask

    // Monitor: every cycle is an output beat; compare against the queued expectation.
    always @(posedge clk) begin : monitor
        obs_t e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            tests++;
            if (a !== e) begin
                fails++;
                show_fail("outputs", a, e);
            end
        end
    end

    initial begin
        reset = 1'b1; btn = '0; pts_1 = 1'b0; pts_2 = 1'b0; x = '0; y = '0;
        m_reset();
        do_reset();

        // Idle in NEWGAME; stray points are ignored.
        for (int i = 0; i < 1000; i++) tstep(4'b0000, ($urandom % 50) == 0, ($urandom % 50) == 0);

        // Serve.
        repeat (5) tstep(4'b0001, 1'b0, 1'b0);
        repeat (3) tstep(4'b0000, 1'b0, 1'b0);

        // Long pts_1 level scores once; held button serves when the timer expires.
        repeat (50) tstep(4'b0001, 1'b1, 1'b0);
        wait_state(1, 4'b0001, "serve_after_p1");

        // Simultaneous points: no score change.
        tstep(4'b0000, 1'b1, 1'b1);
        wait_state(1, 4'b0100, "serve_after_tie");

        // Player 2 wins the game.
        for (int k = 0; k < WIN; k++) begin
            repeat (3) tstep(4'b0000, 1'b0, 1'b1);
            if (k < WIN - 1) wait_state(1, 4'b1000, "serve_p2");
        end
        wait_state(0, 4'b0000, "over_to_newgame");

        // Reset in NEWBALL with the timer mid-count.
        wait_state(1, 4'b0010, "serve_again");
        tstep(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 1000 && m_tmr != 60; i++) tstep(4'b0000, 1'b0, 1'b0);
        do_reset();
        repeat (20) tstep(4'b0000, 1'b0, 1'b0);

        // Random play.
        for (int i = 0; i < 15000; i++) begin
            bit [3:0] b;
            b = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000;
            if (($urandom % 4000) == 0) do_reset();
            else tstep(b, ($urandom % 30) == 0, ($urandom % 30) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
